// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - shared register-file widths and forward-bus stage type
package defines_pkg;

    localparam int REG_ADDR_WD = 7;
    localparam int REG_DATA_WD = 128;
    localparam int NUM_REGS    = 128;
    localparam int NUM_FWD_STG = 6;

    typedef struct packed {
        logic                   vld;
        logic [REG_ADDR_WD-1:0] addr;
        logic [REG_DATA_WD-1:0] data;
    } fwd_stage_t;

    // Entry 0 is stage s2 (youngest), entry NUM_FWD_STG-1 is stage s7 (oldest).
    typedef fwd_stage_t [NUM_FWD_STG-1:0] fwd_bus_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - youngest-stage-wins operand select for one read port
module fwd_sel
    import defines_pkg::*;
(
    input  logic [REG_ADDR_WD-1:0] rd_addr_i,
    input  fwd_bus_t               fwd_i,
    input  logic [REG_DATA_WD-1:0] rf_data_i,
    output logic [REG_DATA_WD-1:0] sel_data_o
);

    // Walk oldest to youngest so the lowest matching stage overwrites last.
    always_comb begin
        sel_data_o = rf_data_i;
        for (int i = NUM_FWD_STG - 1; i >= 0; i--) begin
            if (fwd_i[i].vld && (fwd_i[i].addr == rd_addr_i)) begin
                sel_data_o = fwd_i[i].data;
            end
        end
    end

endmodule

// File: rtl/rf_fwd_unit.sv
// rtl/rf_fwd_unit.sv - 128x128 register file with even-pipe result forwarding
module rf_fwd_unit
    import defines_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic [REG_ADDR_WD-1:0] rd_addr_ra,
    input  logic [REG_ADDR_WD-1:0] rd_addr_rb,
    input  logic [REG_ADDR_WD-1:0] rd_addr_rc,
    input  logic                   rf_vld_s2_ep,
    input  logic                   rf_vld_s3_ep,
    input  logic                   rf_vld_s4_ep,
    input  logic                   rf_vld_s5_ep,
    input  logic                   rf_vld_s6_ep,
    input  logic                   rf_vld_s7_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s2_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s3_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s4_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s5_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s6_ep,
    input  logic [REG_ADDR_WD-1:0] rf_addr_s7_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s2_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s3_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s4_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s5_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s6_ep,
    input  logic [REG_DATA_WD-1:0] rf_data_s7_ep,
    output logic [REG_DATA_WD-1:0] out_RA,
    output logic [REG_DATA_WD-1:0] out_RB,
    output logic [REG_DATA_WD-1:0] out_RC,
    output logic                   out_vld
);

    fwd_bus_t fwd;

    assign fwd[0] = {rf_vld_s2_ep, rf_addr_s2_ep, rf_data_s2_ep};
    assign fwd[1] = {rf_vld_s3_ep, rf_addr_s3_ep, rf_data_s3_ep};
    assign fwd[2] = {rf_vld_s4_ep, rf_addr_s4_ep, rf_data_s4_ep};
    assign fwd[3] = {rf_vld_s5_ep, rf_addr_s5_ep, rf_data_s5_ep};
    assign fwd[4] = {rf_vld_s6_ep, rf_addr_s6_ep, rf_data_s6_ep};
    assign fwd[5] = {rf_vld_s7_ep, rf_addr_s7_ep, rf_data_s7_ep};

    logic [REG_DATA_WD-1:0] regs_q [NUM_REGS];
    logic [REG_DATA_WD-1:0] sel_ra;
    logic [REG_DATA_WD-1:0] sel_rb;
    logic [REG_DATA_WD-1:0] sel_rc;
    logic [REG_DATA_WD-1:0] out_ra_q;
    logic [REG_DATA_WD-1:0] out_rb_q;
    logic [REG_DATA_WD-1:0] out_rc_q;
    logic                   out_vld_q;

    // Array reads see the pre-edge contents; same-edge s7 data arrives via the forward path.
    fwd_sel u_sel_ra (
        .rd_addr_i  (rd_addr_ra),
        .fwd_i      (fwd),
        .rf_data_i  (regs_q[rd_addr_ra]),
        .sel_data_o (sel_ra)
    );

    fwd_sel u_sel_rb (
        .rd_addr_i  (rd_addr_rb),
        .fwd_i      (fwd),
        .rf_data_i  (regs_q[rd_addr_rb]),
        .sel_data_o (sel_rb)
    );

    fwd_sel u_sel_rc (
        .rd_addr_i  (rd_addr_rc),
        .fwd_i      (fwd),
        .rf_data_i  (regs_q[rd_addr_rc]),
        .sel_data_o (sel_rc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_vld_s7_ep) begin
            regs_q[rf_addr_s7_ep] <= rf_data_s7_ep;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ra_q  <= '0;
            out_rb_q  <= '0;
            out_rc_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= rd_en;
            if (rd_en) begin
                out_ra_q <= sel_ra;
                out_rb_q <= sel_rb;
                out_rc_q <= sel_rc;
            end
        end
    end

    assign out_RA  = out_ra_q;
    assign out_RB  = out_rb_q;
    assign out_RC  = out_rc_q;
    assign out_vld = out_vld_q;

endmodule
